// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the memory control unit and the convolver bank.
// Covers kernel load, multi-block image processing with a fixed read-to-write
// pipeline latency, and readback address stepping while idle.
// PIPE_LAT is expected to be at least 1 and K_LEN to fit in the address width.
module conv_seq_ctrl #(
   parameter int NB_ADDRESS = 4,
   parameter int PIPE_LAT   = 5,
   parameter int NB_BLK     = 8,
   parameter int K_LEN      = 3
) (
   input  logic                  CLK100MHZ,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_kload,
   input  logic                  i_next_data,
   input  logic [NB_ADDRESS-1:0] i_rows,
   input  logic [NB_BLK-1:0]     i_nblk,
   output logic                  o_sop,
   output logic                  o_eop,
   output logic                  o_chblk,
   output logic [NB_ADDRESS-1:0] o_RAddr,
   output logic [NB_ADDRESS-1:0] o_WAddr,
   output logic                  o_valid,
   output logic                  o_wvalid,
   output logic                  o_ki,
   output logic [NB_BLK-1:0]     o_blk
);

   localparam int CNT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

   localparam logic [CNT_W-1:0]      PIPE_LAT_C = CNT_W'(PIPE_LAT);
   localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
   localparam logic [NB_ADDRESS-1:0] ADDR_ZERO  = {NB_ADDRESS{1'b0}};
   localparam logic [NB_ADDRESS-1:0] ADDR_ONE   = NB_ADDRESS'(1'b1);
   localparam logic [NB_ADDRESS-1:0] K_LAST_C   = NB_ADDRESS'(K_LEN - 1);
   localparam logic [NB_BLK-1:0]     BLK_ZERO   = {NB_BLK{1'b0}};
   localparam logic [NB_BLK-1:0]     BLK_ONE    = NB_BLK'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KLOAD = 2'd1,
      ST_RUN   = 2'd2,
      ST_CHBLK = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  start_prev_q, start_prev_d;
   logic                  kload_prev_q, kload_prev_d;
   logic                  next_prev_q, next_prev_d;
   logic [NB_ADDRESS-1:0] rows_q, rows_d;
   logic [NB_BLK-1:0]     nblk_q, nblk_d;
   logic [NB_ADDRESS-1:0] raddr_q, raddr_d;
   logic [NB_ADDRESS-1:0] waddr_q, waddr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NB_BLK-1:0]     blk_q, blk_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic                  chblk_q, chblk_d;
   logic                  valid_q, valid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  ki_q, ki_d;

   logic                  start_edge_s;
   logic                  kload_edge_s;
   logic                  next_edge_s;
   logic [CNT_W-1:0]      cnt_inc_s;

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      start_edge_s = i_start & ~start_prev_q;
      kload_edge_s = i_kload & ~kload_prev_q;
      next_edge_s  = i_next_data & ~next_prev_q;
      cnt_inc_s    = (cnt_q < PIPE_LAT_C) ? (cnt_q + CNT_ONE) : cnt_q;

      // Edge history tracks the raw levels every cycle, whatever the state.
      start_prev_d = i_start;
      kload_prev_d = i_kload;
      next_prev_d  = i_next_data;

      state_d  = state_q;
      rows_d   = rows_q;
      nblk_d   = nblk_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      cnt_d    = cnt_q;
      blk_d    = blk_q;
      sop_d    = sop_q;
      eop_d    = eop_q;
      chblk_d  = 1'b0;
      valid_d  = valid_q;
      wvalid_d = wvalid_q;
      ki_d     = ki_q;

      case (state_q)
         ST_IDLE: begin
            sop_d    = 1'b0;
            eop_d    = 1'b1;
            valid_d  = 1'b0;
            wvalid_d = 1'b0;
            ki_d     = 1'b0;
            if (kload_edge_s) begin
               state_d = ST_KLOAD;
               raddr_d = ADDR_ZERO;
               eop_d   = 1'b0;
               valid_d = 1'b1;
               ki_d    = 1'b1;
            end else if (start_edge_s) begin
               state_d = ST_RUN;
               rows_d  = i_rows;
               nblk_d  = i_nblk;
               raddr_d = ADDR_ZERO;
               waddr_d = ADDR_ZERO;
               cnt_d   = CNT_ZERO;
               blk_d   = BLK_ZERO;
               sop_d   = 1'b1;
               eop_d   = 1'b0;
               valid_d = 1'b1;
            end else if (next_edge_s) begin
               // Readback wraps at the row count latched by the last run.
               raddr_d = (raddr_q == rows_q) ? ADDR_ZERO : (raddr_q + ADDR_ONE);
            end else begin
               raddr_d = raddr_q;
            end
         end

         ST_KLOAD: begin
            sop_d    = 1'b0;
            eop_d    = 1'b0;
            wvalid_d = 1'b0;
            if (raddr_q == K_LAST_C) begin
               state_d = ST_IDLE;
               raddr_d = ADDR_ZERO;
               eop_d   = 1'b1;
               valid_d = 1'b0;
               ki_d    = 1'b0;
            end else begin
               raddr_d = raddr_q + ADDR_ONE;
               valid_d = 1'b1;
               ki_d    = 1'b1;
            end
         end

         ST_RUN: begin
            sop_d = 1'b1;
            eop_d = 1'b0;
            ki_d  = 1'b0;
            if (wvalid_q && (waddr_q == rows_q)) begin
               raddr_d  = ADDR_ZERO;
               waddr_d  = ADDR_ZERO;
               cnt_d    = CNT_ZERO;
               valid_d  = 1'b0;
               wvalid_d = 1'b0;
               if (blk_q < nblk_q) begin
                  state_d = ST_CHBLK;
                  chblk_d = 1'b1;
                  blk_d   = blk_q + BLK_ONE;
               end else begin
                  state_d = ST_IDLE;
                  sop_d   = 1'b0;
                  eop_d   = 1'b1;
               end
            end else begin
               // Read side saturates on the last row while the write side drains.
               raddr_d  = (raddr_q < rows_q) ? (raddr_q + ADDR_ONE) : raddr_q;
               cnt_d    = cnt_inc_s;
               wvalid_d = (cnt_inc_s == PIPE_LAT_C);
               waddr_d  = wvalid_q ? (waddr_q + ADDR_ONE) : ADDR_ZERO;
               valid_d  = 1'b1;
            end
         end

         ST_CHBLK: begin
            state_d  = ST_RUN;
            sop_d    = 1'b1;
            eop_d    = 1'b0;
            valid_d  = 1'b1;
            wvalid_d = 1'b0;
            ki_d     = 1'b0;
            raddr_d  = ADDR_ZERO;
            waddr_d  = ADDR_ZERO;
            cnt_d    = CNT_ZERO;
         end

         default: begin
            state_d  = ST_IDLE;
            sop_d    = 1'b0;
            eop_d    = 1'b1;
            valid_d  = 1'b0;
            wvalid_d = 1'b0;
            ki_d     = 1'b0;
            raddr_d  = ADDR_ZERO;
            waddr_d  = ADDR_ZERO;
            cnt_d    = CNT_ZERO;
         end
      endcase
   end

   // State, edge-history and output registers with synchronous reset.
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b1;
         kload_prev_q <= 1'b1;
         next_prev_q  <= 1'b1;
         rows_q       <= ADDR_ZERO;
         nblk_q       <= BLK_ZERO;
         raddr_q      <= ADDR_ZERO;
         waddr_q      <= ADDR_ZERO;
         cnt_q        <= CNT_ZERO;
         blk_q        <= BLK_ZERO;
         sop_q        <= 1'b0;
         eop_q        <= 1'b1;
         chblk_q      <= 1'b0;
         valid_q      <= 1'b0;
         wvalid_q     <= 1'b0;
         ki_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         kload_prev_q <= kload_prev_d;
         next_prev_q  <= next_prev_d;
         rows_q       <= rows_d;
         nblk_q       <= nblk_d;
         raddr_q      <= raddr_d;
         waddr_q      <= waddr_d;
         cnt_q        <= cnt_d;
         blk_q        <= blk_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         chblk_q      <= chblk_d;
         valid_q      <= valid_d;
         wvalid_q     <= wvalid_d;
         ki_q         <= ki_d;
      end
   end

   assign o_sop    = sop_q;
   assign o_eop    = eop_q;
   assign o_chblk  = chblk_q;
   assign o_RAddr  = raddr_q;
   assign o_WAddr  = waddr_q;
   assign o_valid  = valid_q;
   assign o_wvalid = wvalid_q;
   assign o_ki     = ki_q;
   assign o_blk    = blk_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: table-driven kernel-load vectors, directed
// multi-cycle sequences and randomized operations checked against a
// trace-generating reference model.
module tb_conv_seq_ctrl;

   localparam int P  = 5;
   localparam int KL = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start, i_kload, i_next_data;
   logic [3:0] i_rows;
   logic [7:0] i_nblk;
   logic       o_sop, o_eop, o_chblk, o_valid, o_wvalid, o_ki;
   logic [3:0] o_RAddr, o_WAddr;
   logic [7:0] o_blk;

   conv_seq_ctrl #(
      .NB_ADDRESS(4), .PIPE_LAT(P), .NB_BLK(8), .K_LEN(KL)
   ) dut (
      .CLK100MHZ(clk), .rst(rst),
      .i_start(i_start), .i_kload(i_kload), .i_next_data(i_next_data),
      .i_rows(i_rows), .i_nblk(i_nblk),
      .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk),
      .o_RAddr(o_RAddr), .o_WAddr(o_WAddr),
      .o_valid(o_valid), .o_wvalid(o_wvalid), .o_ki(o_ki), .o_blk(o_blk)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic       chblk;
      logic       valid;
      logic       wvalid;
      logic       ki;
      logic [3:0] raddr;
      logic [3:0] waddr;
      logic [7:0] blk;
   } out_t;

   typedef struct {
      logic  start;
      logic  kload;
      logic  next;
      out_t  exp;
      string name;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   model_rows  = 0;
   int   model_raddr = 0;
   int   model_blk   = 0;
   out_t trace[$];

   function automatic out_t mk(input bit sop, input bit eop, input bit chblk,
                               input bit valid, input bit wvalid, input bit ki,
                               input int raddr, input int waddr, input int blk);
      out_t o;
      o.sop = sop; o.eop = eop; o.chblk = chblk; o.valid = valid;
      o.wvalid = wvalid; o.ki = ki;
      o.raddr = 4'(raddr); o.waddr = 4'(waddr); o.blk = 8'(blk);
      return o;
   endfunction

   function automatic out_t idle_exp();
      return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_raddr, 0, model_blk);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t e);
      out_t a;
      a = {o_sop, o_eop, o_chblk, o_valid, o_wvalid, o_ki, o_RAddr, o_WAddr, o_blk};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t: got sop=%0b eop=%0b chblk=%0b valid=%0b wvalid=%0b ki=%0b raddr=%0d waddr=%0d blk=%0d | expected sop=%0b eop=%0b chblk=%0b valid=%0b wvalid=%0b ki=%0b raddr=%0d waddr=%0d blk=%0d",
                  name, $time, a.sop, a.eop, a.chblk, a.valid, a.wvalid, a.ki, a.raddr, a.waddr, a.blk,
                  e.sop, e.eop, e.chblk, e.valid, e.wvalid, e.ki, e.raddr, e.waddr, e.blk);
      end
   endtask

   // Reference model: a run is a list of blocks, each PIPE_LAT+rows+1 cycles
   // long; reads ramp then hold on the last row, writes trail by PIPE_LAT.
   task automatic build_run(input int rows, input int nblk);
      trace.delete();
      for (int b = 0; b <= nblk; b++) begin
         for (int c = 0; c <= P + rows; c++) begin
            trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, (c >= P), 1'b0,
                               (c < rows) ? c : rows, (c >= P) ? (c - P) : 0, b));
         end
         if (b < nblk) begin
            trace.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, b + 1));
         end
      end
      model_rows  = rows;
      model_raddr = 0;
      model_blk   = nblk;
      trace.push_back(idle_exp());
   endtask

   task automatic do_run(input int rows, input int nblk, input bit noise, input string name);
      build_run(rows, nblk);
      i_rows = 4'(rows); i_nblk = 8'(nblk);
      i_start = 1'b1; i_kload = 1'b0; i_next_data = 1'b0;
      for (int k = 0; k < trace.size(); k++) begin
         step();
         check(name, trace[k]);
         if (noise && (k + 1 < trace.size())) begin
            i_start     = 1'($urandom_range(0, 1));
            i_kload     = 1'($urandom_range(0, 1));
            i_next_data = 1'($urandom_range(0, 1));
            i_rows      = 4'($urandom_range(0, 15));
            i_nblk      = 8'($urandom_range(0, 255));
         end else begin
            i_start = 1'b0; i_kload = 1'b0; i_next_data = 1'b0;
         end
      end
      i_start = 1'b0; i_kload = 1'b0; i_next_data = 1'b0;
      step();
      check({name, "_idle"}, idle_exp());
   endtask

   task automatic do_next(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         i_next_data = 1'b1;
         i_rows = 4'($urandom_range(0, 15));
         step();
         model_raddr = (model_raddr == model_rows) ? 0 : model_raddr + 1;
         check(name, idle_exp());
         step();
         check({name, "_hold"}, idle_exp());
         i_next_data = 1'b0;
         step();
         check({name, "_low"}, idle_exp());
      end
   endtask

   task automatic do_kload(input bit with_start);
      vec_t tbl[6];
      tbl[0] = '{1'b1, 1'b1, 1'b0, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,0,0,model_blk), "kload_c0"};
      tbl[1] = '{1'b1, 1'b1, 1'b0, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1,0,model_blk), "kload_c1"};
      tbl[2] = '{1'b0, 1'b1, 1'b1, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2,0,model_blk), "kload_c2"};
      tbl[3] = '{1'b1, 1'b1, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,0,0,model_blk), "kload_done"};
      tbl[4] = '{1'b1, 1'b1, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,0,0,model_blk), "kload_held"};
      tbl[5] = '{1'b0, 1'b0, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,0,0,model_blk), "kload_low"};
      model_raddr = 0;
      for (int r = 0; r < 6; r++) begin
         i_start     = tbl[r].start & with_start;
         i_kload     = tbl[r].kload;
         i_next_data = (r == 2) ? tbl[r].next : 1'b0;
         step();
         check(tbl[r].name, tbl[r].exp);
      end
      i_start = 1'b0; i_kload = 1'b0; i_next_data = 1'b0;
   endtask

   task automatic do_reset(input int rows, input int nblk, input int at);
      int lim;
      build_run(rows, nblk);
      lim = (at < trace.size()) ? at : trace.size() - 1;
      i_rows = 4'(rows); i_nblk = 8'(nblk);
      i_start = 1'b1;
      for (int k = 0; k < lim; k++) begin
         step();
         check("rst_pre", trace[k]);
      end
      rst = 1'b1;
      step();
      model_rows = 0; model_raddr = 0; model_blk = 0;
      check("rst_mid", idle_exp());
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_no_relaunch", idle_exp());
      end
      i_start = 1'b0;
      step();
      check("rst_after", idle_exp());
   endtask

   initial begin
      rst = 1'b1;
      i_start = 1'b1; i_kload = 1'b1; i_next_data = 1'b1;
      i_rows = 4'd0; i_nblk = 8'd0;
      step();
      step();
      check("reset", idle_exp());
      rst = 1'b0;
      step();
      check("reset_held_inputs", idle_exp());
      step();
      check("reset_held_inputs2", idle_exp());
      i_start = 1'b0; i_kload = 1'b0; i_next_data = 1'b0;
      step();
      check("reset_release", idle_exp());

      do_kload(1'b1);
      do_run(15, 0, 1'b0, "run15");
      do_run(7, 2, 1'b1, "multiblk");
      do_run(3, 0, 1'b0, "run3");
      do_next(5, "next");
      do_reset(9, 1, 8);
      do_run(0, 1, 1'b1, "run0");

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: do_run($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd_run");
            1: do_kload(1'($urandom_range(0, 1)));
            2: do_next($urandom_range(1, 6), "rnd_next");
            default: do_reset($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 60));
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
